// File: rtl/konix_joy_pkg.sv
// Shared bit-position constants, pedal width and pedal state encoding for the
// Konix joystick mapper.
package konix_joy_pkg;

  // Host-side joystick bits (active-high)
  localparam int H_RIGHT = 0;
  localparam int H_LEFT  = 1;
  localparam int H_DOWN  = 2;
  localparam int H_UP    = 3;
  localparam int H_FIRE1 = 4;
  localparam int H_FIRE2 = 5;
  localparam int H_ACCEL = 6;
  localparam int H_BRAKE = 7;

  // Konix-side port bits (active-low)
  localparam int K_PEDAL0 = 0;
  localparam int K_PEDAL1 = 1;
  localparam int K_FIRE1  = 2;
  localparam int K_FIRE2  = 3;
  localparam int K_LEFT   = 4;
  localparam int K_RIGHT  = 5;
  localparam int K_UP     = 6;
  localparam int K_DOWN   = 7;

  localparam int PEDAL_W = 8;

  typedef enum logic [1:0] {
    PS_IDLE     = 2'd0,
    PS_RISE     = 2'd1,
    PS_FALL     = 2'd2,
    PS_HOLD_MAX = 2'd3
  } pedal_state_t;

  // Digital pedal switch: pressed once the analog travel reaches half scale.
  function automatic logic [1:0] pedal_switch(input logic [PEDAL_W-1:0] v);
    return v[PEDAL_W-1] ? 2'b10 : 2'b11;
  endfunction

endpackage

// File: rtl/konix_pedal_ramp.sv
// Per-port analog pedal emulation: a frame-rate ramp driven by the accel and
// brake buttons, saturating at both ends of the 8-bit travel.
module konix_pedal_ramp
  import konix_joy_pkg::*;
#(
  parameter int PEDAL_STEP = 8
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               accel,
  input  logic               brake,
  output logic [PEDAL_W-1:0] value
);

  localparam logic [8:0] STEP_UP = 9'(PEDAL_STEP);
  localparam logic [8:0] STEP_DN = 9'(2 * PEDAL_STEP);

  pedal_state_t       state;
  pedal_state_t       state_nxt;
  logic [PEDAL_W-1:0] value_nxt;

  function automatic logic [PEDAL_W-1:0] sat_add(input logic [PEDAL_W-1:0] v,
                                                 input logic [8:0]         inc);
    logic [8:0] sum;
    sum = {1'b0, v} + inc;
    return (sum > 9'd255) ? '1 : sum[PEDAL_W-1:0];
  endfunction

  function automatic logic [PEDAL_W-1:0] sat_sub(input logic [PEDAL_W-1:0] v,
                                                 input logic [8:0]         dec);
    logic signed [8:0] diff;
    diff = $signed({1'b0, v}) - $signed(dec);
    return (diff < 0) ? '0 : diff[PEDAL_W-1:0];
  endfunction

  // Brake dominates accel; releasing both lets the pedal spring back slowly.
  always_comb begin
    state_nxt = state;
    value_nxt = value;
    if (brake) begin
      value_nxt = sat_sub(value, STEP_DN);
      state_nxt = (value_nxt == '0) ? PS_IDLE : PS_FALL;
    end else if (accel) begin
      value_nxt = (state == PS_HOLD_MAX) ? value : sat_add(value, STEP_UP);
      state_nxt = (value_nxt == '1) ? PS_HOLD_MAX : PS_RISE;
    end else if (state != PS_IDLE) begin
      value_nxt = sat_sub(value, STEP_UP);
      state_nxt = (value_nxt == '0) ? PS_IDLE : PS_FALL;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= PS_IDLE;
      value <= '0;
    end else if (frame_tick) begin
      state <= state_nxt;
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/konix_joy_mapper.sv
// Maps host joysticks onto active-low Konix ports with pedal emulation and
// optional port swap; build with KONIX_JOY_AUTOFIRE_EN for fire1 autofire.
module konix_joy_mapper
  import konix_joy_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int AF_FRAMES  = 4,
  parameter int PEDAL_STEP = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic [8*NUM_PORTS-1:0] joy_in,
  input  logic                   cfg_swap,
  input  logic [NUM_PORTS-1:0]   cfg_autofire,
  output logic [8*NUM_PORTS-1:0] joy_out,
  output logic [8*NUM_PORTS-1:0] pedal_out
);

  logic [NUM_PORTS-1:0][7:0] joy_reg;
  logic                      swap_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_reg  <= '0;
      swap_reg <= 1'b0;
    end else begin
      joy_reg  <= joy_in;
      swap_reg <= cfg_swap;
    end
  end

`ifdef KONIX_JOY_AUTOFIRE_EN
  localparam logic [3:0] AF_LAST = 4'(AF_FRAMES - 1);

  logic [NUM_PORTS-1:0] af_en_reg;
  logic [3:0]           af_cnt;
  logic                 af_phase;

  // af_phase high means the fire contact is currently closed.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_en_reg <= '0;
      af_cnt    <= '0;
      af_phase  <= 1'b1;
    end else begin
      af_en_reg <= cfg_autofire;
      if (frame_tick) begin
        if (af_cnt == AF_LAST) begin
          af_cnt   <= '0;
          af_phase <= ~af_phase;
        end else begin
          af_cnt <= af_cnt + 4'd1;
        end
      end
    end
  end
`else
  logic unused_autofire;
  assign unused_autofire = ^cfg_autofire;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // Only ports 0 and 1 take part in the swap.
    localparam int PARTNER = (NUM_PORTS >= 2 && p < 2) ? (p ^ 1) : p;

    logic [7:0]         src;
    logic               fire1_n;
    logic [7:K_FIRE1]   map_reg;
    logic [PEDAL_W-1:0] pedal;

    assign src = swap_reg ? joy_reg[PARTNER] : joy_reg[p];

`ifdef KONIX_JOY_AUTOFIRE_EN
    assign fire1_n = (af_en_reg[p] && src[H_FIRE1]) ? ~af_phase : ~src[H_FIRE1];
`else
    assign fire1_n = ~src[H_FIRE1];
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        map_reg <= '1;
      end else begin
        map_reg[K_DOWN]  <= ~src[H_DOWN];
        map_reg[K_UP]    <= ~src[H_UP];
        map_reg[K_RIGHT] <= ~src[H_RIGHT];
        map_reg[K_LEFT]  <= ~src[H_LEFT];
        map_reg[K_FIRE2] <= ~src[H_FIRE2];
        map_reg[K_FIRE1] <= fire1_n;
      end
    end

    // The ramp stays bound to this output port; only its button source swaps.
    konix_pedal_ramp #(
      .PEDAL_STEP(PEDAL_STEP)
    ) u_ramp (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .frame_tick(frame_tick),
      .accel     (src[H_ACCEL]),
      .brake     (src[H_BRAKE]),
      .value     (pedal)
    );

    assign pedal_out[p*8 +: 8] = pedal;
    assign joy_out[p*8 +: 8]   = {map_reg, pedal_switch(pedal)};
  end

endmodule

// File: tb/tb_konix_joy_mapper.sv
// Directed testbench for konix_joy_mapper (two ports, step 8, autofire period 4).
module tb_konix_joy_mapper;

  logic        clk_sys;
  logic        reset_n;
  logic        frame_tick;
  logic [15:0] joy_in;
  logic        cfg_swap;
  logic [1:0]  cfg_autofire;
  logic [15:0] joy_out;
  logic [15:0] pedal_out;

  int n_checks = 0;
  int n_errors = 0;

  konix_joy_mapper #(
    .NUM_PORTS (2),
    .AF_FRAMES (4),
    .PEDAL_STEP(8)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .joy_in      (joy_in),
    .cfg_swap    (cfg_swap),
    .cfg_autofire(cfg_autofire),
    .joy_out     (joy_out),
    .pedal_out   (pedal_out)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    @(posedge clk_sys);
    #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    int exp;
    joy_in       = '0;
    cfg_swap     = 1'b0;
    cfg_autofire = '0;
    frame_tick   = 1'b0;
    reset_n      = 1'b0;
    cyc(3);
    chk("rst_joy", joy_out, 16'hFFFF);
    chk("rst_pedal", pedal_out, 16'h0000);

    reset_n = 1'b1;
    cyc(2);
    chk("idle_joy", joy_out, 16'hFFFF);

    // Two-cycle latency and direction mapping
    joy_in = 16'h0004;
    cyc(1);
    chk("lat_1cyc", joy_out, 16'hFFFF);
    cyc(1);
    chk("down_p0", joy_out, 16'hFF7F);

    joy_in = 16'h0A21;
    cyc(2);
    chk("mix_dirs", joy_out, 16'hAFD7);

    joy_in = 16'h1000;
    cyc(2);
    chk("fire1_p1", joy_out, 16'hFBFF);

    cfg_swap = 1'b1;
    cyc(2);
    chk("swap_fire", joy_out, 16'hFFFB);

    joy_in = 16'h0008;
    cyc(2);
    chk("swap_up", joy_out, 16'hBFFF);

    // Accel ramp on port 0
    cfg_swap = 1'b0;
    joy_in   = 16'h0040;
    cyc(2);
    chk("accel_nodir", joy_out, 16'hFFFF);
    for (int k = 1; k <= 33; k++) begin
      frame();
      exp = (8 * k > 255) ? 255 : 8 * k;
      chk("ramp_val", pedal_out[7:0], exp);
      chk("ramp_sw", joy_out[1:0], (exp >= 128) ? 2 : 3);
    end
    chk("ramp_p1_idle", pedal_out[15:8], 0);
    cyc(5);
    chk("hold_no_tick", pedal_out[7:0], 255);

    // Swap moves the accel source to port 1; port 0 ramp keeps its value and decays
    cfg_swap = 1'b1;
    cyc(2);
    frame();
    chk("swap_pedal", pedal_out, 16'h08F7);
    cfg_swap = 1'b0;
    joy_in   = '0;

    // Asynchronous reset mid-ramp at 96
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    joy_in  = 16'h0044;
    cyc(2);
    for (int k = 0; k < 12; k++) frame();
    chk("ramp_96", pedal_out[7:0], 96);
    chk("pre_rst_joy", joy_out, 16'hFF7F);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_pedal", pedal_out, 16'h0000);
    chk("async_joy", joy_out, 16'hFFFF);
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    chk("post_rst_joy", joy_out, 16'hFF7F);

    // Brake beats accel, saturates at zero
    for (int k = 0; k < 5; k++) frame();
    chk("ramp_40", pedal_out[7:0], 40);
    joy_in = 16'h00C0;
    cyc(2);
    frame();
    chk("brake_24", pedal_out[7:0], 24);
    frame();
    chk("brake_8", pedal_out[7:0], 8);
    frame();
    chk("brake_sat0", pedal_out[7:0], 0);
    frame();
    chk("brake_stay0", pedal_out[7:0], 0);

    // Release decay
    joy_in = 16'h0040;
    cyc(2);
    frame();
    frame();
    chk("ramp_16", pedal_out[7:0], 16);
    joy_in = '0;
    cyc(2);
    frame();
    chk("decay_8", pedal_out[7:0], 8);
    frame();
    frame();
    chk("decay_0", pedal_out[7:0], 0);

    // Autofire on port 0
    reset_n = 1'b0;
    cyc(1);
    reset_n      = 1'b1;
    joy_in       = 16'h0010;
    cfg_autofire = 2'b01;
    cyc(2);
    chk("af_start", joy_out[2], 0);
`ifdef KONIX_JOY_AUTOFIRE_EN
    for (int k = 1; k <= 16; k++) begin
      frame();
      cyc(1);
      chk("af_phase", joy_out[2], ((k / 4) % 2 != 0) ? 1 : 0);
    end
    cfg_autofire = 2'b00;
    cyc(2);
    for (int k = 1; k <= 4; k++) begin
      frame();
      cyc(1);
      chk("af_off", joy_out[2], 0);
    end
`else
    for (int k = 1; k <= 8; k++) begin
      frame();
      cyc(1);
      chk("fire_pass", joy_out[2], 0);
    end
`endif
    chk("af_p1", joy_out[15:8], 8'hFF);
    joy_in = '0;
    cyc(2);
    chk("fire_release", joy_out[2], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
